// File: rtl/cpu_program_sequencer.sv
// Program store plus issue/settle/capture sequencer feeding the accumulator CPU's IN0.
// Each non-halt word yields one result beat; a held beat stalls the run until it is accepted.
module cpu_program_sequencer #(
  parameter int          DEPTH         = 16,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [7:0]  HALT_WORD     = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [7:0]                 load_data,
  input  logic                       clear,
  input  logic                       start,
  output logic [7:0]                 instr_out,
  input  logic [7:0]                 cpu_alu,
  input  logic [7:0]                 cpu_acc,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [15:0]                res_data,
  output logic [$clog2(DEPTH)-1:0]   res_index,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   len;
  logic [AW-1:0]   pc;
  logic [CW-1:0]   cnt;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      cur_word;
  logic            load_wr;
  logic            start_ok;
  logic            last_word;
  logic            beat_xfer;

  assign load_ready = (state == IDLE) && (len < LW'(DEPTH));
  // clear wins over a same-cycle load, so the word is dropped
  assign load_wr    = load_valid && load_ready && !clear;
  assign start_ok   = (state == IDLE) && start && !clear && (len != '0);
  assign cur_word   = mem[pc];
  assign last_word  = ({1'b0, pc} == (len - LW'(1)));
  assign beat_xfer  = res_valid && res_ready;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (load_wr)
      mem[len[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_ok) state_nxt = ISSUE;
      ISSUE:  state_nxt = (cur_word == HALT_WORD) ? DONE : SETTLE;
      SETTLE: if (cnt == '0) state_nxt = HOLD;
      HOLD:   if (beat_xfer) state_nxt = last_word ? DONE : ISSUE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= '0;
      pc        <= '0;
      cnt       <= '0;
      instr_out <= 8'h00;
      res_valid <= 1'b0;
      res_data  <= 16'h0000;
      res_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear)        len <= '0;
          else if (load_wr) len <= len + LW'(1);
          if (start_ok)     pc  <= '0;
        end
        ISSUE: begin
          // a halt word leaves instr_out at the previous instruction
          if (cur_word != HALT_WORD) begin
            instr_out <= cur_word;
            cnt       <= CW'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            res_data  <= {cpu_acc, cpu_alu};
            res_index <= pc;
            res_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (beat_xfer) begin
            res_valid <= 1'b0;
            if (!last_word) pc <= pc + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_program_sequencer.md
# cpu_program_sequencer

Drives the 8-bit accumulator CPU from the instruction side. It stores a short program loaded over a valid/ready port, issues one instruction at a time on the CPU instruction input (IN0), waits a fixed settle interval, then captures the CPU's ALU result (OUT0) and accumulator value (OUT1). Each capture is handed downstream as one result beat on a valid/ready port. The block sits between the testbench or host loader and the CPU top, and provides the sequential control the CPU datapath lacks.

## Interface
- DEPTH, 16, program memory depth in words; power of two, at least 2.
- SETTLE_CYCLES, 2, full clock cycles instr_out is held stable before capture; at least 1.
- HALT_WORD, 8'hFF, instruction value that ends the run without being issued.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  the block can accept a program word.
- load_data  in  8  program word, written at address len.
- clear  in  1  empties the program (len <= 0). Honoured only in IDLE.
- start  in  1  begins a run. Honoured only in IDLE with len > 0.
- instr_out  out  8  instruction to the CPU IN0.
- cpu_alu  in  8  CPU OUT0 (ALU result).
- cpu_acc  in  8  CPU OUT1 (accumulator read).
- res_valid  out  1  a result beat is presented.
- res_ready  in  1  the consumer accepts the beat.
- res_data  out  16  {cpu_acc, cpu_alu} as sampled at capture.
- res_index  out  clog2(DEPTH)  program address of the captured instruction.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, high while in DONE.

## Operation
- States: IDLE, ISSUE, SETTLE, HOLD, DONE.
- Registers:
  - len: clog2(DEPTH)+1 bits.
  - pc: clog2(DEPTH) bits.
  - cnt: settle counter.
  - Program memory: DEPTH×8, not reset.
- IDLE:
  - load_ready = (len < DEPTH).
  - load_valid && load_ready writes mem[len] and increments len.
  - clear has priority over load in the same cycle.
  - start && len > 0: pc <= 0, go to ISSUE. If load is also accepted in that cycle, the new word is part of the program.
  - start with len == 0 is ignored.
- Outside IDLE: load_ready = 0; start and clear are ignored.
- ISSUE:
  - If mem[pc] == HALT_WORD: go to DONE; instr_out is unchanged; no result beat is produced for that word.
  - Otherwise: instr_out <= mem[pc], cnt <= SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - If cnt == 0: res_data <= {cpu_acc, cpu_alu}, res_index <= pc, res_valid <= 1, go to HOLD.
  - Otherwise cnt decrements.
- HOLD:
  - res_data and res_index are stable while res_valid is high and not yet accepted.
  - On res_valid && res_ready: res_valid <= 0.
  - If pc == len-1, go to DONE. Otherwise pc <= pc+1 and go to ISSUE.
- DONE: done = 1 for that single cycle, then go to IDLE. len is retained, so the same program can be restarted.
- instr_out holds its last issued value in every state.
- Reset values:
  - state IDLE; len 0; pc 0; cnt 0.
  - instr_out 8'h00; res_valid 0; res_data 16'h0000; res_index 0.
  - busy 0; done 0.
  - load_ready 1 after reset, because len is 0 in IDLE.
- Reset asserted mid-run forces all of the above immediately. A pending res_valid drops without a handshake.

## Timing
- Start is sampled at edge E0. mem[0] appears on instr_out after E1.
- Capture occurs at edge E(1+SETTLE_CYCLES); res_valid is high after it.
- With res_ready tied high, each instruction costs SETTLE_CYCLES+2 cycles (4 at default). A transfer on edge Ek leads to ISSUE, and the next instr_out update happens at Ek+1.
- Program of L words, no halt, ready tied high: last transfer at E(L·(SETTLE_CYCLES+2)); done is high in the following cycle; busy falls one cycle later.
- Back-pressure: each cycle res_ready is low in HOLD adds one cycle. No capture is lost and no instruction is skipped.
- The CPU must settle combinationally within SETTLE_CYCLES; cpu_alu and cpu_acc are sampled only at the capture edge.

## Test plan
- Load 8'h11, 8'h22, 8'h33; start; res_ready=1; CPU model returns alu = instr+1, acc = instr. Expect:
  - beats {8'h11,8'h12} idx0, {8'h22,8'h23} idx1, {8'h33,8'h34} idx2;
  - done pulse exactly at cycle 13 after E0;
  - busy low at cycle 14.
- Same program with res_ready low for 5 cycles on beat 1. Expect res_data={8'h22,8'h23} held constant, no idx2 beat before acceptance, and total run length 5 cycles longer.
- Load 8'h05, 8'hFF, 8'h07; start. Expect exactly one beat (idx0), then done; instr_out stays 8'h05.
- Load DEPTH words. Expect load_ready=0 and a further load_valid ignored. Then clear together with load_valid: expect len=0 with the word not written, and start ignored (busy stays 0).
- Assert rst_n=0 mid-SETTLE of instruction 2. Expect:
  - instr_out=8'h00, res_valid=0, busy=0 immediately;
  - load_ready=1 after reset;
  - start with no reload ignored.
